// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, nibble count, saturation limits.
// Pure declarations; no latency and no flow control of its own.
// Imported by the serial add/sub controller.
package alu_pkg;

    localparam int NIBBLES = 4;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // On signed overflow the true result carries the sign of operand A.
    function automatic logic [15:0] sat_limit(input logic a_sign);
        return a_sign ? SAT_MIN : SAT_MAX;
    endfunction

endpackage

// File: rtl/nibble_addsub.sv
// 4-bit ripple add slice; b is pre-inverted by the caller for subtraction.
// Combinational, zero latency; no handshake.
// Exposes the carry into the top bit so the caller can detect signed overflow.
module nibble_addsub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);

    logic [4:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
        end
    end

    assign cout = w_c[4];
    assign c3   = w_c[3];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// 16-bit signed add/sub computed one nibble per cycle through a single 4-bit slice.
// Latency 5 cycles from accepted start to the done pulse; one op per 5 cycles.
// start is honoured only while ready; starts during busy are ignored.
import alu_pkg::*;

module serial_addsub_ctrl #(
    parameter int WIDTH = 16,
    parameter int NIB   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_sat;
    logic [1:0]       r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_ovfl;
    logic             r_busy;
    logic             r_done;

    logic             w_ready;
    logic             w_accept;
    logic             w_last;
    logic [NIB-1:0]   w_slice_a;
    logic [NIB-1:0]   w_slice_b;
    logic [NIB-1:0]   w_slice_sum;
    logic             w_slice_cout;
    logic             w_slice_c3;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_final;

    assign w_ready  = (r_state == IDLE) || (r_state == DONE);
    assign w_accept = start && w_ready;
    assign w_last   = (r_idx == 2'(NIBBLES - 1));

    assign w_slice_a = r_a[r_idx*NIB +: NIB];
    assign w_slice_b = r_b[r_idx*NIB +: NIB] ^ {NIB{r_sub}};

    nibble_addsub u_slice (
        .a    (w_slice_a),
        .b    (w_slice_b),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout),
        .c3   (w_slice_c3)
    );

    // Only meaningful on the top nibble, where c3/cout straddle bit 15.
    assign w_ovf = w_slice_c3 ^ w_slice_cout;

    always_comb begin
        w_acc_final                = r_acc;
        w_acc_final[WIDTH-1 -: NIB] = w_slice_sum;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? CALC : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == CALC);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_sat   <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_ovfl  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_sub   <= sub;
            r_sat   <= sat;
            r_idx   <= '0;
            r_carry <= sub;
            r_acc   <= '0;
        end else if (r_state == CALC) begin
            r_acc[r_idx*NIB +: NIB] <= w_slice_sum;
            r_carry                 <= w_slice_cout;
            r_idx                   <= r_idx + 2'd1;
            // Visible result is updated only once the final nibble is known.
            if (w_last) begin
                r_ovfl <= w_ovf;
                r_sum  <= (r_sat && w_ovf) ? sat_limit(r_a[WIDTH-1]) : w_acc_final;
            end
        end
    end

    assign ready = w_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign Sum   = r_sum;
    assign Ovfl  = r_ovfl;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed cases plus a random sweep
// against an integer-arithmetic reference with saturation.
module tb_serial_addsub_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        sub;
    logic        sat;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic        Ovfl;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_sum = 16'h0000;
    logic        exp_ovf = 1'b0;

    serial_addsub_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .sub   (sub),
        .sat   (sat),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Ovfl  (Ovfl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic st,
                                   output logic [15:0] r, output logic ov);
        int x;
        int y;
        int t;
        x  = int'($signed(a));
        y  = int'($signed(b));
        t  = s ? (x - y) : (x + y);
        ov = (t > 32767) || (t < -32768);
        if (ov && st) r = (t > 0) ? 16'h7FFF : 16'h8000;
        else          r = 16'(t);
    endfunction

    // Called at #1 after an edge while the DUT is ready; returns in the done cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic st, input logic poke);
        logic [15:0] er;
        logic        eo;
        ref_op(a, b, s, st, er, eo);
        start = 1'b1; A = a; B = b; sub = s; sat = st;
        @(posedge clk); #1;
        start = 1'b0; A = 16'($urandom); B = 16'($urandom); sub = ~s; sat = ~st;
        for (int i = 0; i < 4; i++) begin
            chk("busy_calc", 16'(busy), 16'd1);
            chk("done_calc", 16'(done), 16'd0);
            chk("ready_calc", 16'(ready), 16'd0);
            chk("sum_hold", Sum, exp_sum);
            if (poke && i == 1) begin
                start = 1'b1; A = 16'hFFFF;
            end
            if (poke && i == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        chk("done_pulse", 16'(done), 16'd1);
        chk("busy_done", 16'(busy), 16'd0);
        chk("ready_done", 16'(ready), 16'd1);
        chk("sum", Sum, er);
        chk("ovfl", 16'(Ovfl), 16'(eo));
        exp_sum = er;
        exp_ovf = eo;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("idle_done", 16'(done), 16'd0);
        chk("idle_ready", 16'(ready), 16'd1);
        chk("idle_sum", Sum, exp_sum);
        chk("idle_ovfl", 16'(Ovfl), 16'(exp_ovf));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; sub = 1'b0; sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 16'(ready), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_sum", Sum, 16'h0000);
        chk("rst_ovfl", 16'(Ovfl), 16'd0);
        @(negedge clk); rst = 1'b0;
        idle_cycle();

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        chk("dir_carry_chain", Sum, 16'h2233);
        idle_cycle();

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("dir_posovf_wrap", Sum, 16'h8000);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        chk("dir_posovf_sat", Sum, 16'h7FFF);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        chk("dir_negovf_wrap", Sum, 16'h7FFF);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
        chk("dir_negovf_sat", Sum, 16'h8000);
        chk("dir_negovf_flag", 16'(Ovfl), 16'd1);

        // Started from the done cycle: no bubble.
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
        chk("dir_b2b_sum", Sum, 16'hFFFE);
        chk("dir_b2b_ovfl", 16'(Ovfl), 16'd0);
        idle_cycle();

        run_op(16'h0100, 16'h0100, 1'b0, 1'b0, 1'b1);
        chk("dir_busy_start_ignored", Sum, 16'h0200);
        idle_cycle();

        start = 1'b1; A = 16'h1111; B = 16'h2222; sub = 1'b0; sat = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_sum", Sum, 16'h0000);
        chk("midrst_ovfl", 16'(Ovfl), 16'd0);
        chk("midrst_ready", 16'(ready), 16'd1);
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_done", 16'(done), 16'd0);
        exp_sum = 16'h0000;
        exp_ovf = 1'b0;
        @(negedge clk); rst = 1'b0;
        idle_cycle();
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
        chk("after_rst_sum", Sum, 16'h0007);
        idle_cycle();

        for (int n = 0; n < 200; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            for (int m = 0; m < 4; m++) begin
                run_op(ra, rb, m[0], m[1], 1'b0);
                if ($urandom_range(0, 1) == 1) idle_cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
